// File: rtl/uart_defs.sv
// Shared definitions for the UART TX arbitration path.
package uart_defs;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } ArbState_t;

    localparam int UART_ARB_MAX_REQ = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from rr_ptr, wrapping at N_REQ.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_any
);

    always_comb begin
        int pos;
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        pos     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Explicit wrap so non-power-of-two N_REQ never selects a missing requester
            pos = int'(rr_ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!win_any && req[pos[PTR_W-1:0]]) begin
                win_any                = 1'b1;
                win_idx                = pos[PTR_W-1:0];
                win_oh[pos[PTR_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the UART TX byte channel among N_REQ requesters.
// Optional per-grant burst cap when built with UART_TX_ARB_BURST_LIMIT_EN (uses MAX_BURST).
module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic                 tx_enable_i,
    output logic [7:0]           tx_d_o,
    output logic                 tx_d_valid_o,
    input  logic                 tx_d_ready_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > UART_ARB_MAX_REQ || MAX_BURST < 1) begin : g_bad_param
        $error("uart_tx_arbiter: N_REQ must be 2..16 and MAX_BURST >= 1");
    end

    ArbState_t          state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, gidx_q;
    logic [N_REQ-1:0]   grant_q;
    logic [7:0]         tx_d_p1;
    logic               vld_p1;
    logic [N_REQ-1:0]   win_oh;
    logic [PTR_W-1:0]   win_idx;
    logic               win_any;
    logic               slot_free, accept, arb_start, release_grant, burst_hit;
    logic [7:0]         sel_byte;

    uart_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req     (req_valid_i),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    // Output slot can take a byte when empty or draining this cycle
    assign slot_free     = tx_enable_i & (~vld_p1 | tx_d_ready_i);
    assign accept        = (state_q == ARB_BUSY) & slot_free & req_valid_i[gidx_q];
    assign arb_start     = (state_q == ARB_IDLE) & tx_enable_i & win_any;
    assign release_grant = accept & (req_last_i[gidx_q] | burst_hit);

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_q == PTR_W'(i)) begin
                sel_byte = req_data_i[8*i +: 8];
            end
        end
    end

`ifdef UART_TX_ARB_BURST_LIMIT_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0] burst_cnt_q;

    // A grant is cut when this accept would make the count reach MAX_BURST
    assign burst_hit = (burst_cnt_q == BURST_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else if (arb_start) begin
            burst_cnt_q <= '0;
        end else if (accept) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
        end
    end
`else
    assign burst_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (arb_start)     state_d = ARB_BUSY;
            ARB_BUSY: if (release_grant) state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == ARB_BUSY) begin
            req_ready_o[gidx_q] = slot_free;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else if (arb_start) begin
            grant_q <= win_oh;
            gidx_q  <= win_idx;
        end else if (release_grant) begin
            grant_q  <= '0;
            rr_ptr_q <= (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
    end

    // Stage p1: one-entry output register toward the UART TX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_d_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (accept) begin
            tx_d_p1 <= sel_byte;
            vld_p1  <= 1'b1;
        end else if (tx_d_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign tx_d_o       = tx_d_p1;
    assign tx_d_valid_o = vld_p1;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == ARB_BUSY) | vld_p1;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
    localparam int LIMIT = MB;
`else
    localparam int LIMIT = 1000000;
`endif

    logic           clk, rst_n;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic           tx_enable, tx_d_valid, tx_d_ready, busy;
    logic [7:0]     tx_d;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .tx_enable_i  (tx_enable),
        .tx_d_o       (tx_d),
        .tx_d_valid_o (tx_d_valid),
        .tx_d_ready_i (tx_d_ready),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       rel;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] dq[N][$];
    logic       dl[N][$];
    logic [7:0] obs[$];
    logic [7:0] lit_q[$];
    int         acc_cyc[$];
    int         drn_cyc[$];
    int         cyc_lit[$];
    int         acc_i, out_i, m_ptr, tcyc, checks, errors;
    int         first_grant_cyc, drain_load_cnt;
    int         rdy_lo_from, rdy_lo_to, en_lo_from, en_lo_to;
    logic       trk, prev_acc_any, prev_vld, prev_rdy, prev_en, prev_rel;
    logic [7:0] prev_acc_byte, prev_txd;
    logic [N-1:0] prev_grant;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, expv);
        end
    endtask

    // Packet-level round robin: whole packets (or MAX_BURST slices) in pointer order
    task automatic build_model();
        logic [7:0] mq[N][$];
        logic       ml[N][$];
        int         ptr, w, j, cnt;
        logic       r, l;
        logic [7:0] b;
        exp_t       e;
        for (int i = 0; i < N; i++) begin
            mq[i] = dq[i];
            ml[i] = dl[i];
        end
        ptr = m_ptr;
        forever begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (w < 0 && mq[j].size() > 0) w = j;
            end
            if (w < 0) break;
            cnt = 0;
            r   = 1'b0;
            while (!r && mq[w].size() > 0) begin
                b = mq[w].pop_front();
                l = ml[w].pop_front();
                cnt++;
                r = l || (cnt == LIMIT);
                e.src = w; e.data = b; e.rel = r;
                exp_q.push_back(e);
            end
            ptr = (w + 1) % N;
        end
        m_ptr = ptr;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = dq[i][0];
                req_last[i]        = dl[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        tx_d_ready = !(tcyc >= rdy_lo_from && tcyc < rdy_lo_to);
        tx_enable  = !(tcyc >= en_lo_from && tcyc < en_lo_to);
    endtask

    task automatic step();
        logic [N-1:0] acc;
        logic         drn;
        int           src;
        logic [7:0]   ab;
        @(negedge clk);
        acc = req_valid & req_ready;
        drn = tx_d_valid & tx_d_ready;
        src = -1;
        ab  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                src = i;
                ab  = req_data[8*i +: 8];
            end
        end
        chk("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
        chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        chk("busy", 32'(busy), 32'((grant != 0) || tx_d_valid));
        if (grant != 0)
            chk("ready_level", 32'(|(req_ready & grant)), 32'(tx_enable & (~tx_d_valid | tx_d_ready)));
        if (trk) begin
            chk("out_valid", 32'(tx_d_valid), 32'(prev_acc_any | (prev_vld & ~prev_rdy)));
            if (prev_acc_any) chk("out_load", 32'(tx_d), 32'(prev_acc_byte));
            else if (prev_vld && !prev_rdy) chk("out_hold", 32'(tx_d), 32'(prev_txd));
            if (prev_rel) chk("grant_release", 32'(grant), 32'd0);
            else if (prev_grant != 0) chk("grant_hold", 32'(grant), 32'(prev_grant));
            if (prev_grant == 0 && grant != 0) begin
                if (first_grant_cyc < 0) first_grant_cyc = tcyc;
                chk("arb_enabled", 32'(prev_en), 32'd1);
                if (acc_i < exp_q.size()) chk("grant_owner", 32'(grant), 32'd1 << exp_q[acc_i].src);
                else chk("grant_unexpected", 32'(grant), 32'd0);
            end
        end
        prev_rel = 1'b0;
        if (src >= 0) begin
            acc_cyc.push_back(tcyc);
            if (acc_i < exp_q.size()) begin
                chk("accept_src", 32'(src), 32'(exp_q[acc_i].src));
                chk("accept_byte", 32'(ab), 32'(exp_q[acc_i].data));
                prev_rel = exp_q[acc_i].rel;
                acc_i++;
            end else begin
                chk("accept_extra", 32'(src), 32'hFFFF_FFFF);
            end
        end
        if (drn) begin
            drn_cyc.push_back(tcyc);
            obs.push_back(tx_d);
            if (out_i < exp_q.size()) begin
                chk("drain_byte", 32'(tx_d), 32'(exp_q[out_i].data));
                out_i++;
            end else begin
                chk("drain_extra", 32'd1, 32'd0);
            end
        end
        if (drn && src >= 0) drain_load_cnt++;
        trk           = 1'b1;
        prev_acc_any  = (src >= 0);
        prev_acc_byte = ab;
        prev_vld      = tx_d_valid;
        prev_rdy      = tx_d_ready;
        prev_en       = tx_enable;
        prev_txd      = tx_d;
        prev_grant    = grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(dq[i].pop_front());
                void'(dl[i].pop_front());
            end
        end
        tcyc++;
        drive();
    endtask

    task automatic begin_test();
        exp_q.delete(); obs.delete(); acc_cyc.delete(); drn_cyc.delete();
        acc_i = 0; out_i = 0; tcyc = 0;
        first_grant_cyc = -1; drain_load_cnt = 0;
        rdy_lo_from = 0; rdy_lo_to = 0; en_lo_from = 0; en_lo_to = 0;
    endtask

    task automatic add_pkt(input int r, input logic [7:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            dq[r].push_back(base + 8'(k));
            dl[r].push_back(k == len - 1);
        end
    endtask

    task automatic start_test();
        build_model();
        drive();
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (out_i < exp_q.size() && n < budget) begin
            step();
            n++;
        end
        if (out_i < exp_q.size()) chk("timeout", 32'(out_i), 32'(exp_q.size()));
        chk("byte_count", 32'(obs.size()), 32'(exp_q.size()));
    endtask

    task automatic chk_obs(input string name);
        chk({name, "_len"}, 32'(obs.size()), 32'(lit_q.size()));
        for (int k = 0; k < obs.size() && k < lit_q.size(); k++)
            chk(name, 32'(obs[k]), 32'(lit_q[k]));
    endtask

    task automatic chk_cycles(input string name, input logic use_acc);
        int got[$];
        got = use_acc ? acc_cyc : drn_cyc;
        chk({name, "_len"}, 32'(got.size()), 32'(cyc_lit.size()));
        for (int k = 0; k < got.size() && k < cyc_lit.size(); k++)
            chk(name, 32'(got[k]), 32'(cyc_lit[k]));
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            dq[i].delete();
            dl[i].delete();
        end
        begin_test();
        m_ptr = 0;
        trk   = 1'b0;
        prev_rel = 1'b0;
        drive();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tx_d"}, 32'(tx_d), 32'd0);
        chk({tag, "_tx_valid"}, 32'(tx_d_valid), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        req_data = '0; req_valid = '0; req_last = '0;
        tx_enable = 1'b0; tx_d_ready = 1'b0;
        clear_all();
        #1 rst_n = 1'b0;
        #11;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single requester, three-byte packet
        begin_test();
        add_pkt(1, 8'hA1, 3);
        start_test();
        run_to_done(50);
        lit_q = '{8'hA1, 8'hA2, 8'hA3};
        chk_obs("t1_bytes");
        chk("t1_first_grant_cycle", 32'(first_grant_cyc), 32'd1);
        cyc_lit = '{2, 3, 4};
        chk_cycles("t1_drain_cycles", 1'b0);

        // Pointer left at 2 by the previous packet
        begin_test();
        for (int i = 0; i < N; i++) add_pkt(i, 8'(i * 16 + 11), 1);
        start_test();
        run_to_done(50);
        lit_q = '{8'h2B, 8'h3B, 8'h0B, 8'h1B};
        chk_obs("t1b_order");

        rst_n = 1'b0;
        clear_all();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All four valid with single-byte packets from pointer 0
        begin_test();
        add_pkt(0, 8'h00, 1); add_pkt(0, 8'h01, 1);
        add_pkt(1, 8'h10, 1); add_pkt(2, 8'h20, 1); add_pkt(3, 8'h30, 1);
        start_test();
        run_to_done(80);
        lit_q = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01};
        chk_obs("t2_order");
        cyc_lit = '{1, 3, 5, 7, 9};
        chk_cycles("t2_accept_cycles", 1'b1);

        // Downstream backpressure for five cycles mid-packet
        begin_test();
        add_pkt(2, 8'h40, 6);
        rdy_lo_from = 3; rdy_lo_to = 8;
        start_test();
        run_to_done(80);
        lit_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        chk_obs("t3_bytes");
        chk("t3_drain_and_load", 32'(drain_load_cnt > 0), 32'd1);

        // Disabled while idle: no grant until enable returns
        begin_test();
        add_pkt(0, 8'h50, 1);
        en_lo_from = 0; en_lo_to = 10;
        start_test();
        run_to_done(80);
        chk("t4a_first_grant_cycle", 32'(first_grant_cyc), 32'd11);

        // Disabled for ten cycles mid-packet
        begin_test();
        add_pkt(1, 8'h60, 8);
        en_lo_from = 4; en_lo_to = 14;
        start_test();
        run_to_done(80);
        lit_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        chk_obs("t4b_bytes");

        // Reset while the output register holds a byte
        begin_test();
        add_pkt(3, 8'h70, 5);
        rdy_lo_from = 0; rdy_lo_to = 1000;
        start_test();
        repeat (4) step();
        chk("t6_held_before_reset", 32'(tx_d_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_async");
        clear_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin_test();
        add_pkt(0, 8'h80, 1);
        add_pkt(3, 8'h90, 1);
        start_test();
        run_to_done(50);
        lit_q = '{8'h80, 8'h90};
        chk_obs("t6_scan_from_zero");

        // Long packet from req0 competing with req2
        begin_test();
        add_pkt(0, 8'h00, 10);
        add_pkt(2, 8'h20, 2);
        start_test();
        run_to_done(200);
`ifdef UART_TX_ARB_BURST_LIMIT_EN
        lit_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21,
                  8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
`else
        lit_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'h06, 8'h07, 8'h08, 8'h09, 8'h20, 8'h21};
`endif
        chk_obs("t5_order");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
